fishing_level_sequencer: RTL and testbench
==========================================

Name: fishing_level_sequencer

Overview:
- Game-flow controller for the VGA fishing scene.
- Generates the slow game tick and sequences the four fish levels plus the win screen.
- Supplies per-level fish geometry and speed to the sprite/position datapath, and gates which datapath motions are enabled.
- Consumes hook/fish status from the datapath and keeps the score.

Parameters:
TICK_DIV, 500000, clk cycles per game tick (min 2)
REEL_TOP, 105, fish_y at or below which a reeled fish counts as landed
SLACK_TICKS, 30, consecutive ticks without btn_up in REEL before the fish escapes

Ports:
clk  in  1  system clock
rst  in  1  reset
btn_up  in  1  debounced level: reel / strike
btn_down  in  1  debounced level
btn_left  in  1  debounced level
btn_right  in  1  debounced level
hook_hit  in  1  datapath: hook overlaps current fish this frame
fish_y  in  10  datapath: current fish centre row
tick  out  1  one-clk pulse every TICK_DIV clks
load_level  out  1  one-clk pulse: datapath reloads fish x=798, y=fish_y_start, line y=155
level  out  2  current level 0..3
fish_y_start  out  10  level start row
fish_half_h  out  5  fish half height
fish_len  out  7  fish length in pixels
fish_speed  out  3  pixels per tick of fish x motion
fish_visible  out  1  draw fish
line_drop_en  out  1  line may descend
player_move_en  out  1  left/right moves player
reel_en  out  1  datapath moves fish and line up 2 px per tick
win  out  1  win screen active
score  out  8  accumulated points, saturating

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: state LOAD, level 0, score 0, tick 0, load_level 0, win 0, all enables 0, tick counter 0, slack counter 0, button history 0.
- Tick counter: counts 0..TICK_DIV-1 and wraps to 0. tick=1 exactly in the cycle where count==TICK_DIV-1. All state, level, score and button-history updates occur only in tick cycles.
- Button edges: the previous button values are registered on each tick. rise_x = btn_x & ~prev_x.
- Level table (registered, updated with level):
  - level 0: y 470, half 10, len 60, speed 2, points 1
  - level 1: y 380, half 8, len 40, speed 2, points 2
  - level 2: y 290, half 5, len 20, speed 3, points 4
  - level 3: y 200, half 3, len 10, speed 3, points 8
- LOAD:
  - On a tick, load_level pulses high during that same tick cycle only.
  - Next state is FISH. slack counter is cleared.
- FISH:
  - fish_visible=1, line_drop_en=1, player_move_en=1.
  - On a tick with btn_up=1 and hook_hit=1: go to REEL.
- REEL:
  - fish_visible=1, reel_en=btn_up. Movement is frozen.
  - On a tick with fish_y <= REEL_TOP (landed): score = min(255, score+points[level]).
    - If level==3: go to WIN.
    - Otherwise: level+1, go to LOAD.
  - Else, on a tick with btn_up=0: slack counter +1. When the counter reaches SLACK_TICKS, go to LOAD with the level unchanged (escape, no points).
  - Else, on a tick with btn_up=1: slack counter cleared.
  - Landed takes priority over escape in the same tick.
- WIN:
  - win=1, all enables 0, fish_visible=0.
  - On a tick with a rising edge on any of the four buttons: level 0, go to LOAD. score is held (not cleared).
  - A button already held when entering WIN does not restart the game; a new press is required.
- Outputs are registered. Enables follow state with one clk of latency after the transition tick. Reset mid-game returns to LOAD/level 0 immediately.

Test Plan:
- TICK_DIV=4, release rst -> tick high on clk 4, 8, 12…; load_level high exactly at the first tick; level=0, fish_y_start=470, fish_len=60.
- In FISH, assert btn_up with hook_hit=0 for 10 ticks -> stays FISH. Set hook_hit=1 -> REEL on that tick; reel_en=1, player_move_en=0.
- In REEL at level 0, drive fish_y=105 -> score 1, level 1, load_level pulse, fish_y_start=380, half 8.
- In REEL, btn_up low for 29 ticks -> still REEL. At tick 30 -> LOAD, level unchanged, score unchanged. Also check: btn_up pulse at tick 15 restarts the slack count.
- Land all four levels -> score 15, win=1. With btn_right held since before WIN -> stays WIN. Release, then press btn_right -> level 0, LOAD, score still 15.
- Preload score 250, land level 3 -> score saturates at 255.
- Assert rst mid-REEL, asynchronously between clk edges -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fishing_level_sequencer.sv
// Game-flow controller for the fishing scene: slow game tick, level sequencing,
// per-level fish geometry, datapath motion enables and saturating score.
module fishing_level_sequencer #(
  parameter int TICK_DIV    = 500000,
  parameter int REEL_TOP    = 105,
  parameter int SLACK_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       hook_hit_i,
  input  logic [9:0] fish_y_i,
  output logic       tick_o,
  output logic       load_level_o,
  output logic [1:0] level_o,
  output logic [9:0] fish_y_start_o,
  output logic [4:0] fish_half_h_o,
  output logic [6:0] fish_len_o,
  output logic [2:0] fish_speed_o,
  output logic       fish_visible_o,
  output logic       line_drop_en_o,
  output logic       player_move_en_o,
  output logic       reel_en_o,
  output logic       win_o,
  output logic [7:0] score_o
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SLACK_TICKS + 1);

  typedef enum logic [1:0] {LOAD, FISH, REEL, WIN} state_e;

  typedef struct packed {
    logic [9:0] y;
    logic [4:0] half;
    logic [6:0] len;
    logic [2:0] speed;
  } geom_t;

  function automatic geom_t geomOf(input logic [1:0] lvl);
    geom_t g;
    case (lvl)
      2'd0:    g = '{10'd470, 5'd10, 7'd60, 3'd2};
      2'd1:    g = '{10'd380, 5'd8,  7'd40, 3'd2};
      2'd2:    g = '{10'd290, 5'd5,  7'd20, 3'd3};
      default: g = '{10'd200, 5'd3,  7'd10, 3'd3};
    endcase
    return g;
  endfunction

  logic [CW-1:0] cnt_q;
  logic          tick_q;
  state_e        state_q;
  logic [1:0]    level_q;
  geom_t         geom_q;
  logic [7:0]    score_q;
  logic [SW-1:0] slack_q;
  logic [3:0]    btn_prev_q;
  logic          load_level_q, fish_visible_q, line_drop_q, player_move_q, reel_en_q, win_q;

  logic [3:0] btns, rise;
  logic       landed, tick_next;
  logic [8:0] score_sum;
  logic [7:0] score_d;

  assign btns      = {btn_up_i, btn_down_i, btn_left_i, btn_right_i};
  assign rise      = btns & ~btn_prev_q;
  assign landed    = (fish_y_i <= 10'(REEL_TOP));
  assign score_sum = {1'b0, score_q} + {1'b0, (8'd1 << level_q)};
  assign score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
  // Registered tick is set one cycle ahead so it is high while cnt_q == TICK_DIV-1.
  assign tick_next = (cnt_q == CW'(TICK_DIV - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_next;
      cnt_q  <= (cnt_q == CW'(TICK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LOAD;
      level_q        <= 2'd0;
      geom_q         <= geomOf(2'd0);
      score_q        <= 8'd0;
      slack_q        <= '0;
      btn_prev_q     <= 4'd0;
      load_level_q   <= 1'b0;
      fish_visible_q <= 1'b0;
      line_drop_q    <= 1'b0;
      player_move_q  <= 1'b0;
      reel_en_q      <= 1'b0;
      win_q          <= 1'b0;
    end else begin
      // State cannot change in the cycle before a tick, so this lands in the LOAD tick cycle.
      load_level_q   <= tick_next && (state_q == LOAD);
      fish_visible_q <= (state_q == FISH) || (state_q == REEL);
      line_drop_q    <= (state_q == FISH);
      player_move_q  <= (state_q == FISH);
      reel_en_q      <= (state_q == REEL) && btn_up_i;
      win_q          <= (state_q == WIN);

      if (tick_q) begin
        btn_prev_q <= btns;
        case (state_q)
          LOAD: begin
            state_q <= FISH;
            slack_q <= '0;
          end
          FISH: begin
            if (btn_up_i && hook_hit_i) begin
              state_q <= REEL;
              slack_q <= '0;
            end
          end
          REEL: begin
            if (landed) begin
              score_q <= score_d;
              if (level_q == 2'd3) begin
                state_q <= WIN;
              end else begin
                level_q <= level_q + 2'd1;
                geom_q  <= geomOf(level_q + 2'd1);
                state_q <= LOAD;
              end
            end else if (!btn_up_i) begin
              if (slack_q == SW'(SLACK_TICKS - 1)) begin
                state_q <= LOAD;
                slack_q <= '0;
              end else begin
                slack_q <= slack_q + 1'b1;
              end
            end else begin
              slack_q <= '0;
            end
          end
          WIN: begin
            // Only a fresh press restarts; a button held into WIN shows no edge.
            if (|rise) begin
              level_q <= 2'd0;
              geom_q  <= geomOf(2'd0);
              state_q <= LOAD;
            end
          end
          default: state_q <= LOAD;
        endcase
      end
    end
  end

  assign tick_o           = tick_q;
  assign load_level_o     = load_level_q;
  assign level_o          = level_q;
  assign fish_y_start_o   = geom_q.y;
  assign fish_half_h_o    = geom_q.half;
  assign fish_len_o       = geom_q.len;
  assign fish_speed_o     = geom_q.speed;
  assign fish_visible_o   = fish_visible_q;
  assign line_drop_en_o   = line_drop_q;
  assign player_move_en_o = player_move_q;
  assign reel_en_o        = reel_en_q;
  assign win_o            = win_q;
  assign score_o          = score_q;

endmodule

// File: tb/tb_fishing_level_sequencer.sv
// Scoreboard bench for fishing_level_sequencer: a tick-level game model pushes
// expected outputs at each tick and they are compared once the enables settle.
module tb_fishing_level_sequencer;

  localparam int TB_TICK = 4;
  localparam int M_LOAD = 0, M_FISH = 1, M_REEL = 2, M_WIN = 3;

  logic       clk, rst;
  logic       btnUp, btnDown, btnLeft, btnRight, hookHit;
  logic [9:0] fishY;
  logic       tick, loadLevel, fishVisible, lineDropEn, playerMoveEn, reelEn, win;
  logic [1:0] level;
  logic [9:0] fishYStart;
  logic [4:0] fishHalfH;
  logic [6:0] fishLen;
  logic [2:0] fishSpeed;
  logic [7:0] score;

  fishing_level_sequencer #(.TICK_DIV(TB_TICK), .REEL_TOP(105), .SLACK_TICKS(30)) dut (
    .clk(clk), .rst(rst),
    .btn_up_i(btnUp), .btn_down_i(btnDown), .btn_left_i(btnLeft), .btn_right_i(btnRight),
    .hook_hit_i(hookHit), .fish_y_i(fishY),
    .tick_o(tick), .load_level_o(loadLevel), .level_o(level),
    .fish_y_start_o(fishYStart), .fish_half_h_o(fishHalfH), .fish_len_o(fishLen),
    .fish_speed_o(fishSpeed), .fish_visible_o(fishVisible), .line_drop_en_o(lineDropEn),
    .player_move_en_o(playerMoveEn), .reel_en_o(reelEn), .win_o(win), .score_o(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int level, score, win, fishVis, lineDrop, playerMove, reelEn, yStart, half, len, speed;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int mState, mLevel, mScore, mSlack;
  logic [3:0] mPrev;
  time lastTick;

  int yTab[4]     = '{470, 380, 290, 200};
  int halfTab[4]  = '{10, 8, 5, 3};
  int lenTab[4]   = '{60, 40, 20, 10};
  int speedTab[4] = '{2, 2, 3, 3};

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic up, input logic down, input logic left,
                               input logic right, input logic hook, input int fy);
    btnUp = up; btnDown = down; btnLeft = left; btnRight = right;
    hookHit = hook; fishY = 10'(fy);
  endtask

  task automatic modelReset();
    mState = M_LOAD; mLevel = 0; mScore = 0; mSlack = 0; mPrev = 4'd0; lastTick = 0;
  endtask

  // Game rules at tick granularity, using the inputs currently driven.
  task automatic modelTick();
    logic [3:0] b;
    b = {btnUp, btnDown, btnLeft, btnRight};
    if (mState == M_LOAD) begin
      mState = M_FISH; mSlack = 0;
    end else if (mState == M_FISH) begin
      if (btnUp && hookHit) begin mState = M_REEL; mSlack = 0; end
    end else if (mState == M_REEL) begin
      if (int'(fishY) <= 105) begin
        mScore = mScore + (1 << mLevel);
        if (mScore > 255) mScore = 255;
        if (mLevel == 3) mState = M_WIN;
        else begin mLevel++; mState = M_LOAD; end
      end else if (!btnUp) begin
        mSlack++;
        if (mSlack == 30) begin mState = M_LOAD; mSlack = 0; end
      end else mSlack = 0;
    end else begin
      if ((b & ~mPrev) != 4'd0) begin mLevel = 0; mState = M_LOAD; end
    end
    mPrev = b;
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.level = mLevel; e.score = mScore; e.win = (mState == M_WIN);
    e.fishVis = (mState == M_FISH) || (mState == M_REEL);
    e.lineDrop = (mState == M_FISH); e.playerMove = (mState == M_FISH);
    e.reelEn = (mState == M_REEL) && btnUp;
    e.yStart = yTab[mLevel]; e.half = halfTab[mLevel];
    e.len = lenTab[mLevel]; e.speed = speedTab[mLevel];
    return e;
  endfunction

  task automatic stepTick();
    int guard = 0;
    exp_t e;
    while (tick !== 1'b1 && guard < 3 * TB_TICK) begin
      @(negedge clk);
      guard++;
    end
    if (tick !== 1'b1) begin
      checkOutput("tickTimeout", 0, 1);
      return;
    end
    checkOutput("loadLevel", int'(loadLevel), int'(mState == M_LOAD));
    if (lastTick != 0) checkOutput("tickSpacing", int'(($time - lastTick) / 10), TB_TICK);
    lastTick = $time;
    modelTick();
    sb.push_back(predict());
    @(posedge clk); @(posedge clk); @(negedge clk);
    checkOutput("tickLow", int'(tick), 0);
    e = sb.pop_front();
    checkOutput("level", int'(level), e.level);
    checkOutput("score", int'(score), e.score);
    checkOutput("win", int'(win), e.win);
    checkOutput("fishVisible", int'(fishVisible), e.fishVis);
    checkOutput("lineDropEn", int'(lineDropEn), e.lineDrop);
    checkOutput("playerMoveEn", int'(playerMoveEn), e.playerMove);
    checkOutput("reelEn", int'(reelEn), e.reelEn);
    checkOutput("fishYStart", int'(fishYStart), e.yStart);
    checkOutput("fishHalfH", int'(fishHalfH), e.half);
    checkOutput("fishLen", int'(fishLen), e.len);
    checkOutput("fishSpeed", int'(fishSpeed), e.speed);
  endtask

  // Expects LOAD on entry; leaves the game in LOAD of the next level (or WIN).
  task automatic landLevel();
    applyStimulus(1, 0, 0, 0, 1, 300);
    stepTick();
    stepTick();
    applyStimulus(1, 0, 0, 0, 1, 105);
    stepTick();
    applyStimulus(1, 0, 0, 0, 0, 300);
  endtask

  task automatic exitWin();
    applyStimulus(0, 0, 0, 0, 0, 300);
    stepTick();
    applyStimulus(0, 0, 0, 1, 0, 300);
    stepTick();
    applyStimulus(0, 0, 0, 0, 0, 300);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 300);
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rstTick", int'(tick), 0);
    checkOutput("rstLoadLevel", int'(loadLevel), 0);
    checkOutput("rstLevel", int'(level), 0);
    checkOutput("rstScore", int'(score), 0);
    checkOutput("rstWin", int'(win), 0);
    checkOutput("rstEnables", int'({fishVisible, lineDropEn, playerMoveEn, reelEn}), 0);
    checkOutput("rstYStart", int'(fishYStart), 470);
    checkOutput("rstLen", int'(fishLen), 60);
    rst = 1'b0;

    stepTick();

    applyStimulus(1, 0, 0, 0, 0, 300);
    repeat (10) stepTick();
    applyStimulus(1, 0, 0, 0, 1, 300);
    stepTick();
    checkOutput("reelEntered", int'(reelEn), 1);
    applyStimulus(1, 0, 0, 0, 1, 105);
    stepTick();
    checkOutput("firstLandScore", int'(score), 1);

    applyStimulus(1, 0, 0, 0, 1, 300);
    stepTick();
    checkOutput("level1YStart", int'(fishYStart), 380);
    stepTick();
    applyStimulus(0, 0, 0, 0, 0, 300);
    repeat (14) stepTick();
    applyStimulus(1, 0, 0, 0, 0, 300);
    stepTick();
    applyStimulus(0, 0, 0, 0, 0, 300);
    repeat (29) stepTick();
    checkOutput("slack29StillReel", int'(fishVisible && !lineDropEn), 1);
    stepTick();
    checkOutput("escapeLevel", int'(level), 1);
    checkOutput("escapeScore", int'(score), 1);

    landLevel();
    landLevel();
    applyStimulus(1, 0, 0, 0, 1, 300);
    stepTick();
    stepTick();
    applyStimulus(1, 0, 0, 1, 1, 105);
    stepTick();
    checkOutput("winScore", int'(score), 15);
    checkOutput("winFlag", int'(win), 1);
    applyStimulus(0, 0, 0, 1, 0, 300);
    stepTick();
    checkOutput("heldStaysWin", int'(win), 1);
    applyStimulus(0, 0, 0, 0, 0, 300);
    stepTick();
    applyStimulus(0, 0, 0, 1, 0, 300);
    stepTick();
    checkOutput("restartLevel", int'(level), 0);
    checkOutput("restartScore", int'(score), 15);
    applyStimulus(0, 0, 0, 0, 0, 300);

    for (int r = 0; r < 17; r++) begin
      for (int l = 0; l < 4; l++) landLevel();
      exitWin();
    end
    checkOutput("scoreSat", int'(score), 255);

    landLevel();
    applyStimulus(1, 0, 0, 0, 1, 300);
    stepTick();
    stepTick();
    checkOutput("preResetReel", int'(reelEn), 1);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("asyncRstLevel", int'(level), 0);
    checkOutput("asyncRstScore", int'(score), 0);
    checkOutput("asyncRstReel", int'(reelEn), 0);
    checkOutput("asyncRstVisible", int'(fishVisible), 0);
    checkOutput("asyncRstYStart", int'(fishYStart), 470);
    @(negedge clk);
    rst = 1'b0;
    stepTick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
